// File: rtl/simd_add_arb.sv
// Round-robin arbiter sharing one pipelined N-lane SIMD adder among R requesters.
// Define SIMD_ARB_CNT_EN to build saturating per-requester grant counters.
module simd_add_arb #(
  parameter int N   = 4,
  parameter int W   = 10,
  parameter int R   = 3,
  parameter int LAT = 2,
  parameter int CW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R-1:0]      req_valid,
  output logic [R-1:0]      req_ready,
  input  logic [R*N*W-1:0]  req_a,
  input  logic [R*N*W-1:0]  req_b,
  output logic [N*W-1:0]    add_a,
  output logic [N*W-1:0]    add_b,
  input  logic [N*W-1:0]    add_sum,
  output logic [R-1:0]      resp_valid,
  output logic [N*W-1:0]    resp_sum,
  output logic [R*CW-1:0]   grant_cnt
);

  localparam int NW = N * W;
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam logic [IW:0] RN = (IW+1)'(R);

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0] last;
  logic [IW-1:0] win;
  logic [IW:0]   idx;
  logic          found;
  logic          grant;
  logic [R-1:0]  win_oh;
  tag_t          tags [LAT];

  // Rotating search from last+1; idx is one bit wider so the wrap is a single subtract.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < R; k++) begin
      idx = {1'b0, last} + (IW+1)'(k) + (IW+1)'(1);
      if (idx >= RN) idx = idx - RN;
      if (!found && req_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign grant     = found & ~rst;
  assign win_oh    = grant ? (R'(1) << win) : '0;
  assign req_ready = win_oh;

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int r = 0; r < R; r++) begin
      if (win_oh[r]) begin
        add_a = req_a[r*NW +: NW];
        add_b = req_b[r*NW +: NW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= IW'(R - 1);
      resp_valid <= '0;
      resp_sum   <= '0;
      for (int s = 0; s < LAT; s++) tags[s] <= '0;
    end else begin
      if (grant) last <= win;
      tags[0] <= '{v: grant, id: win};
      for (int s = 1; s < LAT; s++) tags[s] <= tags[s-1];
      if (tags[LAT-1].v) begin
        resp_valid <= R'(1) << tags[LAT-1].id;
        resp_sum   <= add_sum;
      end else begin
        resp_valid <= '0;
      end
    end
  end

`ifdef SIMD_ARB_CNT_EN
  for (genvar r = 0; r < R; r++) begin : g_cnt
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (win_oh[r] && req_valid[r] && cnt != '1) begin
        cnt <= cnt + CW'(1);
      end
    end
    assign grant_cnt[r*CW +: CW] = cnt;
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: doc/simd_add_arb.md
# simd_add_arb

Round-robin arbiter and scheduler that shares one pipelined N-lane SIMD adder among R requesters. Each cycle it grants at most one requester, drives that requester's N-lane operand vectors onto the shared adder, and tracks the grant through the adder's fixed latency. When the sum emerges, it is returned to the originating requester. The block sits between requester-side datapaths and a single `(* use_dsp = "simd" *)` adder instance, so one DSP block can serve several clients.

## Interface
Parameters:
- `N`, 4: SIMD lanes per transaction.
- `W`, 10: lane width in bits.
- `R`, 3: number of requesters, 2..8.
- `LAT`, 2: adder latency in cycles from operand presentation to valid sum.
- `CW`, 16: grant-counter width (used only with `SIMD_ARB_CNT_EN`).

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  R: per-requester transaction request.
- `req_ready`  out  R: one-hot grant, or all zero.
- `req_a`  in  R*N*W: operand A. Requester r, lane i is at bits `[(r*N+i)*W +: W]`.
- `req_b`  in  R*N*W: operand B, same packing as `req_a`.
- `add_a`  out  N*W: operand A to the shared adder. Lane i is at `[i*W +: W]`.
- `add_b`  out  N*W: operand B to the shared adder.
- `add_sum`  in  N*W: sum from the shared adder.
- `resp_valid`  out  R: one-hot; marks the requester that owns `resp_sum` this cycle.
- `resp_sum`  out  N*W: registered copy of `add_sum` for the owning transaction.
- `grant_cnt`  out  R*CW: per-requester grant counts. Requester r is at `[r*CW +: CW]`.

## Operation
Arbitration:
- Arbitration is combinational, over `req_valid`.
- The search starts at `(last+1) mod R`, where `last` is the index of the most recent grant.
- The first valid requester found wins and sees `req_ready[r]=1`.
- A handshake is `req_valid[r] & req_ready[r]`.
- After a handshake, `last` is set to r.
- With no request, `last` is unchanged.
- `req_ready` does not depend on any downstream ready; the adder never stalls.

Issue:
- `add_a`/`add_b` are a combinational mux of the winner's operands.
- With no winner, `add_a`/`add_b` are driven to 0.

Tag pipeline:
- A `LAT`-deep shift register carries `{valid, id}`.
- Stage 0 captures `{handshake, winner}` every cycle.
- The tag pipeline shifts unconditionally.

Response:
- At tag stage `LAT-1`, if valid, then on the next edge:
  - `resp_valid <= onehot(id)`;
  - `resp_sum <= add_sum`.
- Otherwise `resp_valid <= 0` and `resp_sum` holds its value.

Arithmetic:
- Arithmetic is performed by the external adder: lane-wise, modulo 2^W, no carry between lanes.
- This block passes sums through unmodified.

Reset (`rst=1` at an edge):
- `last` = R-1, so requester 0 has first priority after reset.
- All tag valids = 0.
- `resp_valid` = 0, `resp_sum` = 0, `grant_cnt` = 0.
- `req_ready` is forced to 0 while `rst` is high.
- Reset mid-flight: the external adder is not reset, but cleared tags discard in-flight sums, so no response is generated for a pre-reset grant.

## Timing
- Handshake in cycle T → `resp_valid`/`resp_sum` for that transaction in cycle T+LAT+1.
- Example: LAT=2, grant at T → response at T+3.
- Throughput is one transaction per cycle across all requesters.
- Back-to-back grants produce back-to-back responses, in grant order.
- A single requester holding `req_valid` while no other requester is valid is granted every cycle.
- All R requesters valid continuously: grants rotate 0,1,…,R-1,0,…. Each requester gets exactly 1/R of cycles and waits at most R-1 cycles.
- `req_valid` may drop without a grant; the block keeps no state per pending request.
- A requester may receive a response and a new grant in the same cycle.

## Configuration
- `SIMD_ARB_CNT_EN` defined:
  - `grant_cnt[r]` increments by 1 on each handshake of requester r.
  - It saturates at 2^CW-1; no wrap.
  - It is cleared by `rst`.
- `SIMD_ARB_CNT_EN` undefined:
  - the counters are not built;
  - `grant_cnt` is tied to 0;
  - all other behaviour is identical.

## Test plan
All scenarios use N=4, W=10, R=3, LAT=2.

- Reset: hold `rst` for 2 cycles with all `req_valid=1` → `req_ready=0`, `resp_valid=0`, `resp_sum=0` throughout. On the first cycle after release, `req_ready=3'b001`.
- Single transaction: requester 1 sends a={1,2,3,1023}, b={4,5,6,1} → 3 cycles after the grant, `resp_valid=3'b010` and `resp_sum` lanes = {5,7,9,0}. The lane-3 wrap must not disturb lane 2.
- Contention: all three requesters valid for 9 cycles → grant order 0,1,2,0,1,2,0,1,2. Responses return in the same order with the correct per-requester sums. With `SIMD_ARB_CNT_EN`, each counter reads 3.
- Sparse requests: requester 2 valid alone, then requester 0 and requester 2 valid together in the next cycle → requester 0 granted (search starts after index 2), then requester 2.
- Reset mid-flight: grant at T, `rst` pulsed at T+1 → no `resp_valid` at T+3. The next post-reset grant's response is correct.
- Counter saturation (`SIMD_ARB_CNT_EN`, CW=4): requester 0 granted 20 times → `grant_cnt[0]=15`.
